// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 active-low keypad, debounces every key and strobes new presses
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk_raw,
    input  logic        rst,
    input  logic [2:0]  col_n,
    output logic [3:0]  row_n,
    output logic [11:0] keystroke,
    output logic        key_down,
    output logic [3:0]  key_code
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    logic [2:0]    col_m, col_s;
    logic [DW-1:0] div;
    logic [1:0]    r;
    logic [11:0]   raw, raw_next, row_mask, ks_next, rise;
    logic [CW-1:0] cnt [12];
    logic [CW-1:0] cnt_next [12];
    logic [3:0]    code_next;
    logic          tick, frame_done;
    assign tick       = div == DW'(SCAN_DIV - 1);
    assign frame_done = tick && r == 2'd3;
    assign row_n      = ~(4'b0001 << r);
    assign row_mask   = 12'b111 << (4'(r) * 4'd3);
    // debounce must see the row-3 bits sampled on this very tick
    assign raw_next   = tick ? (raw & ~row_mask) | ({4{~col_s}} & row_mask) : raw;
    assign rise       = ks_next & ~keystroke;
    always_comb begin
        ks_next = keystroke;
        for (int k = 0; k < 12; k++) begin
            cnt_next[k] = cnt[k];
            if (frame_done) begin
                if (raw_next[k] == keystroke[k])
                    cnt_next[k] = '0;
                else if (cnt[k] == CW'(DEBOUNCE - 1)) begin
                    ks_next[k]  = ~keystroke[k];
                    cnt_next[k] = '0;
                end else
                    cnt_next[k] = cnt[k] + CW'(1);
            end
        end
    end
    always_comb begin
        code_next = key_code;
        for (int k = 11; k >= 0; k--)
            if (rise[k]) code_next = 4'(k);
    end
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            col_m     <= 3'b111;
            col_s     <= 3'b111;
            div       <= '0;
            r         <= '0;
            raw       <= '0;
            keystroke <= '0;
            key_down  <= 1'b0;
            key_code  <= '0;
            for (int k = 0; k < 12; k++) cnt[k] <= '0;
        end else begin
            col_m     <= col_n;
            col_s     <= col_m;
            div       <= tick ? '0 : div + DW'(1);
            r         <= tick ? r + 2'd1 : r;
            raw       <= raw_next;
            keystroke <= ks_next;
            key_down  <= |rise;
            key_code  <= code_next;
            for (int k = 0; k < 12; k++) cnt[k] <= cnt_next[k];
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: edge-counting behavioural model of the scanner checked every cycle plus literal pins
module tb_keypad_scanner;
    logic        clk_raw = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [11:0] keystroke;
    logic        key_down;
    logic [3:0]  key_code;
    logic [11:0] pressed = '0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          e;
    int          run [12];
    logic [11:0] m_raw, m_ks, d1, d2;
    logic        m_kd;
    logic [3:0]  m_kc;

    always #5 clk_raw = ~clk_raw;

    // physical keypad: a held key pulls its column low while its row is driven
    always_comb begin
        col_n = 3'b111;
        for (int i = 0; i < 4; i++)
            if (!row_n[i]) col_n = col_n & ~pressed[i*3 +: 3];
    end

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk_raw(clk_raw), .rst(rst), .col_n(col_n), .row_n(row_n),
        .keystroke(keystroke), .key_down(key_down), .key_code(key_code)
    );

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    // e = edges since reset; row k*4..k*4+3 of each 16-edge frame, sample on edge%4==3
    task automatic model_edge();
        logic [11:0] rose;
        int row;
        if (rst) begin
            e = 0; m_raw = '0; m_ks = '0; m_kd = 1'b0; m_kc = '0;
            for (int k = 0; k < 12; k++) run[k] = 0;
        end else begin
            m_kd = 1'b0;
            row = (e / 4) % 4;
            if (e % 4 == 3)
                for (int c = 0; c < 3; c++) m_raw[row*3 + c] = d2[row*3 + c];
            if (e % 16 == 15) begin
                rose = '0;
                for (int k = 0; k < 12; k++) begin
                    if (m_raw[k] != m_ks[k]) begin
                        run[k]++;
                        if (run[k] == 3) begin
                            run[k] = 0;
                            m_ks[k] = ~m_ks[k];
                            rose[k] = m_ks[k];
                        end
                    end else run[k] = 0;
                end
                if (rose != '0) begin
                    m_kd = 1'b1;
                    for (int k = 11; k >= 0; k--) if (rose[k]) m_kc = 4'(k);
                end
            end
            d2 = d1;
            d1 = pressed;
            e++;
        end
    endtask

    task automatic cyc();
        logic [3:0] exp_row;
        @(posedge clk_raw);
        model_edge();
        @(negedge clk_raw);
        exp_row = ~(4'b0001 << ((e / 4) % 4));
        chk("row_n", {8'h0, row_n}, {8'h0, exp_row});
        chk("keystroke", keystroke, m_ks);
        chk("key_down", {11'h0, key_down}, {11'h0, m_kd});
        chk("key_code", {8'h0, key_code}, {8'h0, m_kc});
    endtask

    task automatic step(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input logic [11:0] dv, input logic [11:0] mv, input logic [11:0] exp);
        chk(name, dv, exp);
        chk({name, "_model"}, mv, exp);
    endtask

    initial begin
        // 1: reset and idle row stepping
        do_reset();
        lit("t1_row0", {8'h0, row_n}, {8'h0, ~(4'b0001 << ((e / 4) % 4))}, 12'h00e);
        lit("t1_ks", keystroke, m_ks, 12'h000);
        step(4);
        lit("t1_row1", {8'h0, row_n}, {8'h0, ~(4'b0001 << ((e / 4) % 4))}, 12'h00d);
        step(28);
        lit("t1_wrap", {8'h0, row_n}, {8'h0, ~(4'b0001 << ((e / 4) % 4))}, 12'h00e);
        // 2: key 4 held for three frames
        do_reset();
        pressed = 12'h010;
        step(47);
        lit("t2_ks_pre", keystroke, m_ks, 12'h000);
        step(1);
        lit("t2_ks", keystroke, m_ks, 12'h010);
        lit("t2_kd", {11'h0, key_down}, {11'h0, m_kd}, 12'h001);
        lit("t2_kc", {8'h0, key_code}, {8'h0, m_kc}, 12'h004);
        step(1);
        lit("t2_kd_off", {11'h0, key_down}, {11'h0, m_kd}, 12'h000);
        // 4: release key 4, clears three frames later without a pulse
        pressed = '0;
        step(46);
        lit("t4_ks_pre", keystroke, m_ks, 12'h010);
        step(1);
        lit("t4_ks", keystroke, m_ks, 12'h000);
        lit("t4_kd", {11'h0, key_down}, {11'h0, m_kd}, 12'h000);
        lit("t4_kc", {8'h0, key_code}, {8'h0, m_kc}, 12'h004);
        // 3: bounce of two frames is rejected
        do_reset();
        pressed = 12'h010;
        step(32);
        pressed = '0;
        step(48);
        lit("t3_ks", keystroke, m_ks, 12'h000);
        lit("t3_kc", {8'h0, key_code}, {8'h0, m_kc}, 12'h000);
        // 5: keys 1 and 9 together, lowest index reported
        do_reset();
        pressed = 12'h202;
        step(48);
        lit("t5_ks", keystroke, m_ks, 12'h202);
        lit("t5_kd", {11'h0, key_down}, {11'h0, m_kd}, 12'h001);
        lit("t5_kc", {8'h0, key_code}, {8'h0, m_kc}, 12'h001);
        // 6: reset mid-frame while key 4 is held
        do_reset();
        pressed = 12'h010;
        step(54);
        do_reset();
        lit("t6_ks", keystroke, m_ks, 12'h000);
        lit("t6_row", {8'h0, row_n}, {8'h0, ~(4'b0001 << ((e / 4) % 4))}, 12'h00e);
        lit("t6_kc", {8'h0, key_code}, {8'h0, m_kc}, 12'h000);
        step(47);
        lit("t6_ks_pre", keystroke, m_ks, 12'h000);
        step(1);
        lit("t6_ks_back", keystroke, m_ks, 12'h010);
        lit("t6_kd", {11'h0, key_down}, {11'h0, m_kd}, 12'h001);
        lit("t6_kc_back", {8'h0, key_code}, {8'h0, m_kc}, 12'h004);
        step(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
